// File: rtl/sample_sched_pkg.sv
// Shared definitions for the sample-netlist list scheduler: node indices,
// operation types, dependency table and FSM states.
package sample_sched_pkg;

    localparam int N_NODES = 11;

    localparam int G = 0;
    localparam int H = 1;
    localparam int I = 2;
    localparam int J = 3;
    localparam int K = 4;
    localparam int L = 5;
    localparam int M = 6;
    localparam int N = 7;
    localparam int O = 8;
    localparam int P = 9;
    localparam int Q = 10;

    typedef enum logic [1:0] {T_AND, T_OR, T_NOT} node_type_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam node_type_e NODE_TYPE [N_NODES] = '{
        T_OR, T_AND, T_NOT, T_OR, T_OR, T_AND, T_AND, T_AND, T_AND, T_NOT, T_NOT
    };

    // Internal predecessors only; primary inputs are always available.
    localparam logic [N_NODES-1:0] PRED [N_NODES] = '{
        11'h000, 11'h000, 11'h000, 11'h000,
        11'h007, 11'h00E, 11'h00C, 11'h060,
        11'h012, 11'h001, 11'h080
    };

    function automatic logic [N_NODES-1:0] type_mask(input node_type_e t);
        logic [N_NODES-1:0] m;
        m = '0;
        for (int idx = 0; idx < N_NODES; idx++) begin
            m[idx] = (NODE_TYPE[idx] == t);
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Selects the first K set bits of a request mask, lowest index first.
module prio_pick #(
    parameter int W = 11,
    parameter int K = 1
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] pick
);

    int cnt;

    always_comb begin
        pick = '0;
        cnt  = 0;
        for (int idx = 0; idx < W; idx++) begin
            if (req[idx] && (cnt < K)) begin
                pick[idx] = 1'b1;
                cnt       = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/sample_list_sched.sv
// Resource-constrained list scheduler that evaluates the sample netlist over
// several cycles, issuing up to N_AND/N_OR/N_NOT operations per cycle.
module sample_list_sched
    import sample_sched_pkg::*;
#(
    parameter int N_AND = 1,
    parameter int N_OR  = 1,
    parameter int N_NOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic        o,
    output logic        p,
    output logic        q,
    output logic [10:0] issue_mask,
    output logic [3:0]  step_cnt
);

    state_e               state;
    logic [N_NODES-1:0]   done_mask;
    logic [N_NODES-1:0]   val;
    logic [5:0]           in_reg;
    logic [N_NODES-1:0]   ready;
    logic [N_NODES-1:0]   pick_and;
    logic [N_NODES-1:0]   pick_or;
    logic [N_NODES-1:0]   pick_not;
    logic [N_NODES-1:0]   node_val;
    logic [N_NODES-1:0]   val_nx;
    logic                 all_done;

    always_comb begin
        ready = '0;
        for (int idx = 0; idx < N_NODES; idx++) begin
            ready[idx] = ((PRED[idx] & ~done_mask) == '0) && !done_mask[idx];
        end
    end

    prio_pick #(.W(N_NODES), .K(N_AND)) u_pick_and (
        .req  (ready & type_mask(T_AND)),
        .pick (pick_and)
    );

    prio_pick #(.W(N_NODES), .K(N_OR)) u_pick_or (
        .req  (ready & type_mask(T_OR)),
        .pick (pick_or)
    );

    prio_pick #(.W(N_NODES), .K(N_NOT)) u_pick_not (
        .req  (ready & type_mask(T_NOT)),
        .pick (pick_not)
    );

    assign issue_mask = (state == S_RUN) ? (pick_and | pick_or | pick_not) : '0;

    // in_reg order is {f,e,d,c,b,a}; values of not-yet-ready nodes are don't-care.
    always_comb begin
        node_val    = '0;
        node_val[G] = in_reg[0] | in_reg[3];
        node_val[H] = in_reg[0] & in_reg[2];
        node_val[I] = ~in_reg[2];
        node_val[J] = in_reg[3] | in_reg[4] | in_reg[5];
        node_val[K] = val[G] | val[H] | val[I];
        node_val[L] = val[H] & val[I] & val[J];
        node_val[M] = val[I] & val[J];
        node_val[N] = val[L] & val[M];
        node_val[O] = in_reg[1] & val[H] & val[K];
        node_val[P] = ~val[G];
        node_val[Q] = ~val[N];
    end

    assign val_nx   = (val & ~issue_mask) | (node_val & issue_mask);
    assign all_done = &(done_mask | issue_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            done_mask <= '0;
            val       <= '0;
            in_reg    <= '0;
            step_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            o         <= 1'b0;
            p         <= 1'b0;
            q         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        in_reg    <= {f, e, d, c, b, a};
                        done_mask <= '0;
                        val       <= '0;
                        step_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    val       <= val_nx;
                    done_mask <= done_mask | issue_mask;
                    step_cnt  <= step_cnt + 4'd1;
                    if (all_done) begin
                        o     <= val_nx[O];
                        p     <= val_nx[P];
                        q     <= val_nx[Q];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sample_list_sched.md
# sample_list_sched

Resource-constrained list scheduler and executor for the `sample` gate netlist (nodes g..q). On `start` it latches the primary inputs a..f and evaluates the netlist over multiple cycles. Each cycle, at most N_AND AND, N_OR OR and N_NOT NOT operations are issued from the ready set in fixed priority order. When every node has been evaluated it presents o/p/q and pulses `done`. This block is the hardware reference for schedules produced by the scheduling flow; its step count and per-cycle issue mask are compared against them.

## Interface
- N_AND, 1, AND units per cycle (legal 1..5)
- N_OR, 1, OR units per cycle (legal 1..3)
- N_NOT, 1, NOT units per cycle (legal 1..3)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin evaluation; sampled only in IDLE
- a, b, c, d, e, f  input  1 each  primary inputs, latched on the accepted `start`
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; o/p/q valid from this cycle on
- o, p, q  output  1 each  registered results, held until the next completion
- issue_mask  output  11  bit per node (bit0=g, 1=h, 2=i, 3=j, 4=k, 5=l, 6=m, 7=n, 8=o, 9=p, 10=q); nodes issued this cycle
- step_cnt  output  4  RUN cycles elapsed; holds the final step count S after completion

## Operation
- Node functions (type, predecessors):
  - g=a|d (OR), h=a&c (AND), i=!c (NOT), j=d|e|f (OR)
  - k=g|h|i (OR), l=h&i&j (AND), m=i&j (AND), n=l&m (AND)
  - o=b&h&k (AND), p=!g (NOT), q=!n (NOT)
- State: done_mask[10:0], val[10:0], in_reg[5:0], FSM {IDLE, RUN, DONE}.
- Ready node: all internal predecessors set in done_mask, and its own done_mask bit clear.
- Issue rule: per type, the lowest-index ready nodes are selected, up to N_<type> of them.
- Issued nodes compute from `val`/`in_reg` and set their `val` and `done_mask` bits at the clock edge ending the cycle.
- IDLE: when `start`=1, latch a..f, clear done_mask and step_cnt, go to RUN. `start` is ignored in RUN and DONE.
- RUN: `issue_mask` = the selected set; step_cnt increments each cycle. If done_mask|issue_mask is all ones, go to DONE and load o/p/q from the final values.
- DONE: `done`=1 for one cycle, then return to IDLE. A `start` in this cycle is ignored.
- The ready set is never empty in RUN (the netlist is acyclic), so there is no deadlock state.
- With N_AND=N_OR=N_NOT=1 the schedule is:
  - step 1: {g,h,i}
  - step 2: {j,p}
  - step 3: {k,l}
  - step 4: {m}
  - step 5: {n}
  - step 6: {o,q}
  - S=6
- With N_AND=2, N_OR=2, N_NOT=1 the schedule is {g,h,i,j}, {k,l,m,p}, {n,o}, {q}; S=4, which equals ASAP.
- Node n is logically constant 0 and q constant 1; the scheduler still issues both nodes.

## Timing
- Reset (asynchronous, active-low) forces:
  - state IDLE
  - busy=0, done=0, o=p=q=0, issue_mask=0, step_cnt=0
  - done_mask=0, val=0
- Reset mid-RUN aborts the evaluation with no done pulse; o/p/q return to 0.
- `start` is accepted at edge E0. RUN occupies cycles 1..S and `done` is high in cycle S+1, so latency is S+1 cycles.
- The next `start` can be accepted in cycle S+2.
- issue_mask is combinational from registered state and is 0 outside RUN.
- o/p/q change only on the edge entering DONE.

## Structure
- Package `sample_sched_pkg` holds:
  - node index constants
  - node type enum {T_AND, T_OR, T_NOT}
  - per-node type table
  - per-node 11-bit predecessor mask
  - FSM state enum
- Sub-module `prio_pick`, parameterised by width W=11 and count K. It takes a ready mask and returns a mask of the first K set bits, lowest index first. Instantiate it once per type.

## Test plan
- Reset asserted mid-RUN (step 3) -> busy, issue_mask, step_cnt and o/p/q all 0 immediately; no done pulse; next `start` runs normally.
- N=1/1/1, inputs a=1 b=1 c=1 d=e=f=0 -> issue sequence 0x007, 0x208, 0x030, 0x040, 0x080, 0x500; step_cnt=6; done 7 cycles after start; o=1 p=0 q=1.
- N=2/2/1, inputs all 0 -> issue sequence 0x00F, 0x270, 0x180, 0x400; step_cnt=4; o=0 p=1 q=1.
- N=5/3/3, inputs a=0 b=0 c=0 d=1 e=f=0 -> S=4; o=0 p=0 q=1.
- `start` held high for the whole run -> one evaluation only; the next run begins in cycle S+2; `start` in the DONE cycle is ignored.
- Inputs a..f toggled during RUN -> results reflect the values latched at start.
